// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states
// and small helpers that decode the operation field.
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } mdu_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Core-to-MDU bus: operation launch, MTHI/MTLO writes and the HI/LO/status view.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mdu_abs_neg.sv
// Conditional two's-complement negate; used both for operand magnitudes and
// for re-applying signs to the finished result.
module mdu_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on unsigned magnitudes, signs fixed at the end.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);

    mdu_state_e       state;
    mdu_state_e       next_state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opnd;
    logic             is_div;
    logic             sa;
    logic             sb;
    logic             bzero;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             busy_s;
    logic             done_s;
    logic             accept;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   prem;
    logic [WIDTH:0]   pdiff;
    logic             ge;

    assign a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .value  (bus.a),
        .negate (a_neg),
        .result (abs_a)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .value  (bus.b),
        .negate (b_neg),
        .result (abs_b)
    );

    // Product is {acc low half, shreg}; quotient sits in shreg, remainder in acc.
    mdu_abs_neg #(.WIDTH(2*WIDTH)) u_neg_prod (
        .value  ({acc[WIDTH-1:0], shreg}),
        .negate (sa ^ sb),
        .result (prod_fix)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_neg_quot (
        .value  (shreg),
        .negate (sa ^ sb),
        .result (quot_fix)
    );

    mdu_abs_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .value  (acc[WIDTH-1:0]),
        .negate (sa),
        .result (rem_fix)
    );

    always_comb begin
        addend = shreg[0] ? {1'b0, opnd} : '0;
        msum   = acc + addend;
        prem   = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        pdiff  = prem - {1'b0, opnd};
        ge     = (prem >= {1'b0, opnd});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.start) next_state = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) next_state = S_FIX;
            S_FIX:   next_state = S_DONE;
            S_DONE:  next_state = bus.start ? S_RUN : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        accept = 1'b0;
        case (state)
            S_RUN, S_FIX: busy_s = 1'b1;
            S_DONE: begin
                done_s = 1'b1;
                accept = bus.start;
            end
            S_IDLE:  accept = bus.start;
            default: ;
        endcase
    end

    // An accepted start takes priority over a same-cycle MTHI/MTLO write.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            acc    <= '0;
            shreg  <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            bzero  <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        shreg  <= op_is_div(bus.op) ? abs_a : abs_b;
                        opnd   <= op_is_div(bus.op) ? abs_b : abs_a;
                        acc    <= '0;
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= op_is_div(bus.op);
                        sa     <= a_neg;
                        sb     <= b_neg;
                        bzero  <= (bus.b == '0);
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdata;
                        if (bus.lo_we) lo_r <= bus.wdata;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (is_div) begin
                        acc   <= ge ? pdiff : prem;
                        shreg <= {shreg[WIDTH-2:0], ge};
                    end else begin
                        acc   <= {1'b0, msum[WIDTH:1]};
                        shreg <= {msum[0], shreg[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        // Divide by zero leaves the remainder equal to the raw dividend already.
                        lo_r <= bzero ? '1 : quot_fix;
                        hi_r <= rem_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_s;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed plus randomised bench for mult_div_unit; expected HI/LO and done
// timing are queued at launch and compared whenever the unit signals done.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;

    mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mult_div_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] modelOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, sq, sr;
        logic [63:0]        ua, ub, uq, ur;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        case (op)
            MDU_MULT:  return sa * sbv;
            MDU_MULTU: return ua * ub;
            MDU_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sbv;
                sr = sa % sbv;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Done is due in the 34th cycle, counting the cycle after the accepting edge as the first.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_done", 64'(bus.done), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.tag, " hi"}, 64'(bus.hi), 64'(e.hi));
                checkOutput({e.tag, " lo"}, 64'(bus.lo), 64'(e.lo));
                checkOutput({e.tag, " done_cycle"}, 64'(cyc), 64'(e.cyc));
                checkOutput({e.tag, " busy_in_done"}, 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic lowe, input bit push, input logic [63:0] expv,
                                 input string tag);
        exp_t e;
        @(negedge clk);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.lo_we = lowe;
        bus.wdata = 32'h55;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.hi  = expv[63:32];
            e.lo  = expv[31:0];
            e.cyc = cyc + WIDTH + 1;
            e.tag = tag;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.lo_we = 1'b0;
        checkOutput({tag, " busy"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < WIDTH + 10) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput({tag, " timeout_pending"}, 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", 64'(bus.busy), 64'd0);
        checkOutput("reset done", 64'(bus.done), 64'd0);
        checkOutput("reset hi", 64'(bus.hi), 64'd0);
        checkOutput("reset lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;

        applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFE_0000_0001, "multu_max");
        waitDone("multu_max");
        applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg");
        waitDone("mult_neg");
        applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
        waitDone("div_neg");
        applyStimulus(MDU_DIVU, 32'h0000_00CE, 32'h0, 1'b0, 1'b1, 64'h0000_00CE_FFFF_FFFF, "divu_zero");
        waitDone("divu_zero");
        applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'h0000_0000_8000_0000, "div_ovf");
        waitDone("div_ovf");

        // Second start and an MTHI during RUN must both be dropped; HI is 0 from the overflow case.
        applyStimulus(MDU_MULT, 32'd1234, 32'hFFFF_FF00, 1'b0, 1'b1,
                      modelOp(MDU_MULT, 32'd1234, 32'hFFFF_FF00), "mult_ignore");
        repeat (3) @(negedge clk);
        bus.op    = MDU_DIVU;
        bus.a     = 32'd99;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        checkOutput("hi_we_in_run", 64'(bus.hi), 64'd0);
        waitDone("mult_ignore");

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) begin
                rop = MDU_DIV;
                ra  = $urandom | 32'h8000_0000;
                rb  = 32'd0;
            end
            if (i == 1) rb = $urandom_range(1, 9);
            applyStimulus(rop, ra, rb, 1'b0, 1'b1, modelOp(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
            waitDone($sformatf("rand%0d", i));
        end

        @(negedge clk);
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_00F0;
        @(negedge clk);
        bus.hi_we = 1'b0;
        checkOutput("mthi hi", 64'(bus.hi), 64'h0000_00F0);
        bus.lo_we = 1'b1;
        bus.wdata = 32'h0000_000F;
        @(negedge clk);
        bus.lo_we = 1'b0;
        checkOutput("mtlo lo", 64'(bus.lo), 64'h0000_000F);
        checkOutput("mtlo hi_kept", 64'(bus.hi), 64'h0000_00F0);

        applyStimulus(MDU_MULTU, 32'd3, 32'd4, 1'b1, 1'b1, 64'h0000_0000_0000_000C, "multu_lowe");
        checkOutput("lo_we_dropped", 64'(bus.lo), 64'h0000_000F);
        waitDone("multu_lowe");

        // Reset in the middle of a divide: no result and no done pulse afterwards.
        applyStimulus(MDU_DIV, 32'd1000, 32'd7, 1'b0, 1'b0, 64'd0, "div_reset");
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset busy", 64'(bus.busy), 64'd0);
        checkOutput("midreset done", 64'(bus.done), 64'd0);
        checkOutput("midreset hi", 64'(bus.hi), 64'd0);
        checkOutput("midreset lo", 64'(bus.lo), 64'd0);
        reset = 1'b0;
        repeat (WIDTH + 8) @(negedge clk);
        checkOutput("postreset busy", 64'(bus.busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
